output_port_allocator: RTL and testbench
========================================

Name: output_port_allocator

Overview:
- Allocates one router output link among NUM_REQ input ports using wormhole switching.
- Arbitration is round-robin. The winner is locked until it sends its tail flit.
- A credit counter tracks free slots in the downstream input buffer, and no flit is granted without a credit.
- One instance sits in front of each output port of the router crossbar. The grant vector drives that output's crossbar mux select.

Parameters:
- NUM_REQ, 5, number of requesting input ports (N, E, S, W, local).
- CREDIT_DEPTH, 4, downstream buffer depth, and therefore the maximum credit count.
- CNT_W, $clog2(CREDIT_DEPTH+1), width of the credit counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  NUM_REQ  req_i[k]=1 means input k presents a flit for this output.
- tail_i  in  NUM_REQ  tail_i[k]=1 means the flit presented by input k is a tail or single-flit packet; qualified by req_i[k].
- credit_return_i  in  1  one pulse returns one credit (downstream freed one slot).
- grant_o  out  NUM_REQ  one-hot grant, or zero; flit k transfers in this cycle when grant_o[k]=1.
- grant_v_o  out  1  equals the OR of grant_o.
- locked_o  out  1  the output is held by an in-progress packet.
- owner_o  out  $clog2(NUM_REQ)  index of the locking input; valid while locked_o=1.
- credit_count_o  out  CNT_W  current credits available.
- credit_err_o  out  1  sticky flag: a credit was returned while the count was already CREDIT_DEPTH.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, owner=0, credits=CREDIT_DEPTH, credit_err_o=0.
  - Outputs under reset: grant_o=0, grant_v_o=0, locked_o=0.
  - Reset mid-packet drops the lock immediately; no flit is granted while rst=1.
- Grant timing:
  - Grant is combinational from the current inputs and registered state, so latency is 0 cycles (grant in the same cycle as the request).
  - The transfer is the grant cycle itself. Requesters do not acknowledge grants.
- Credit gating: when credits==0, grant_o=0 in every state. Requests are held and the lock is kept.
- State IDLE:
  - If credits>0 and req_i!=0, the winner is the first k with req_i[k]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ. grant_o=onehot(winner).
  - If tail_i[winner]=1 (single-flit packet): stay IDLE, rr_ptr <= (winner+1) mod NUM_REQ.
  - Otherwise: go to LOCKED, owner <= winner. rr_ptr is unchanged until the packet ends.
- State LOCKED:
  - Only owner can be granted. grant_o=onehot(owner) iff req_i[owner]=1 and credits>0. Requests from other inputs are ignored.
  - When the owner transfers a flit with tail_i[owner]=1: go to IDLE, rr_ptr <= (owner+1) mod NUM_REQ.
  - If the owner deasserts req (bubble inside a packet): stay LOCKED, grant_o=0.
- Credit counter, evaluated per cycle. "Transfer" means grant_v_o=1.
  - Transfer only: credits-1.
  - credit_return_i only: credits+1.
  - Both in the same cycle: unchanged.
  - Return while credits==CREDIT_DEPTH with no transfer: saturate at CREDIT_DEPTH and set credit_err_o, which stays set until reset.
  - Underflow is impossible because a transfer requires credits>0.
- Outputs locked_o and owner_o are registered state.
- Wrap-around: rr_ptr=NUM_REQ-1 with winner NUM_REQ-1 sets the next rr_ptr to 0.

Decomposition:
- Shared package noc_pkg holds:
  - the port-index constants (PORT_N/E/S/W/L);
  - the allocator state enum alloc_state_t {IDLE, LOCKED};
  - the default NUM_REQ and CREDIT_DEPTH values, shared with the router top and input buffers.
- One sub-module, credit_counter (CREDIT_DEPTH parameter), contains:
  - inputs: clk, rst, consume_i, return_i;
  - outputs: count_o, avail_o, err_o.
  - It owns the saturate and sticky-error rules.
- The round-robin search stays inline as a for-loop priority function in the allocator.

Test Plan:
- Reset, then req_i=5'b00110 with tail_i=5'b00110 (single-flit packets) for 2 cycles:
  - cycle 0: grant_o=00010; cycle 1: grant_o=00100.
  - rr_ptr becomes 3; credit_count_o goes 4→3→2.
- Locking:
  - Setup: req_i=00011, input 0 sends a 3-flit packet (tail_i[0]=1 only on the 3rd flit), and 2 credits are returned during the packet.
  - Expected: grant_o=00001 for 3 cycles with input 1 starved and locked_o=1, owner_o=0.
  - Cycle 4: grant_o=00010.
- Bubble: while locked to input 2, drop req_i[2] for 2 cycles while req_i[0]=1 → grant_o=0 and locked_o stays 1. On reassert, input 2 resumes.
- Credits:
  - With credits exhausted (4 transfers, no returns) and req_i=00001: grant_v_o=0.
  - Pulse credit_return_i: next cycle credit_count_o=1 and grant_o=00001.
  - Simultaneous transfer and return leaves the count unchanged.
- Overflow: with credits=4, pulse credit_return_i → credit_count_o stays 4 and credit_err_o=1 until rst.
- Async reset: assert rst mid-packet between clock edges → grant_o=0 and locked_o=0 immediately, credit_count_o=4. After release, req_i=10000 gives grant_o=10000, searched from rr_ptr=0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared router definitions: port indices, allocator state, default sizing.
// Used by the allocator, the router top and the input buffers.
package noc_pkg;

  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_S = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  localparam int NUM_REQ_DEF      = 5;
  localparam int CREDIT_DEPTH_DEF = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/credit_counter.sv
// Downstream credit tracker: count updates on the clock after consume/return, avail_o is combinational.
// Returns at full count saturate and raise a sticky error; consume is only issued when avail_o is high.
module credit_counter #(
  parameter int CREDIT_DEPTH = 4,
  parameter int CNT_W        = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             consume_i,
  input  logic             return_i,
  output logic [CNT_W-1:0] count_o,
  output logic             avail_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDIT_DEPTH);

  logic [CNT_W-1:0] r_count;
  logic             r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= FULL;
      r_err   <= 1'b0;
    end else begin
      case ({consume_i, return_i})
        2'b10: r_count <= r_count - 1'b1;
        2'b01: begin
          // A return with no free slot outstanding means the downstream lost track.
          if (r_count == FULL) r_err <= 1'b1;
          else                 r_count <= r_count + 1'b1;
        end
        default: r_count <= r_count;
      endcase
    end
  end

  assign count_o = r_count;
  assign avail_o = (r_count != '0);
  assign err_o   = r_err;

endmodule

// File: rtl/output_port_allocator.sv
// Wormhole round-robin allocator for one output link; grant is combinational (0-cycle latency).
// No grant without a downstream credit; a locked packet holds the output through bubbles.
module output_port_allocator
  import noc_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEF,
  parameter int CNT_W        = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         tail_i,
  input  logic                       credit_return_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic                       grant_v_o,
  output logic                       locked_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic [CNT_W-1:0]           credit_count_o,
  output logic                       credit_err_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(NUM_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  alloc_state_t     r_state, w_state_nxt;
  logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0] r_owner, w_owner_nxt;
  logic [IDX_W-1:0] w_winner;
  logic [NUM_REQ-1:0] w_grant;
  logic             w_avail;
  logic             w_ok;

  assign w_winner = rr_pick(req_i, r_rr_ptr);
  // Reset also gates the grant, since the async state clear alone would still allow an IDLE grant.
  assign w_ok     = w_avail & ~rst;

  always_comb begin
    w_grant      = '0;
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_owner_nxt  = r_owner;
    case (r_state)
      IDLE: begin
        if (w_ok && (req_i != '0)) begin
          w_grant[w_winner] = 1'b1;
          if (tail_i[w_winner]) begin
            w_rr_ptr_nxt = rr_next(w_winner);
          end else begin
            w_state_nxt = LOCKED;
            w_owner_nxt = w_winner;
          end
        end
      end
      LOCKED: begin
        if (w_ok && req_i[r_owner]) begin
          w_grant[r_owner] = 1'b1;
          if (tail_i[r_owner]) begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = rr_next(r_owner);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_owner  <= w_owner_nxt;
    end
  end

  credit_counter #(
    .CREDIT_DEPTH (CREDIT_DEPTH),
    .CNT_W        (CNT_W)
  ) u_credit (
    .clk       (clk),
    .rst       (rst),
    .consume_i (grant_v_o),
    .return_i  (credit_return_i),
    .count_o   (credit_count_o),
    .avail_o   (w_avail),
    .err_o     (credit_err_o)
  );

  assign grant_o   = w_grant;
  assign grant_v_o = |w_grant;
  assign locked_o  = (r_state == LOCKED);
  assign owner_o   = r_owner;

endmodule

// File: tb/tb_output_port_allocator.sv
// Bench for output_port_allocator: directed scenarios then random traffic against a cycle model.
module tb_output_port_allocator;

  logic       clk;
  logic       rst;
  logic [4:0] req_i;
  logic [4:0] tail_i;
  logic       credit_return_i;
  logic [4:0] grant_o;
  logic       grant_v_o;
  logic       locked_o;
  logic [2:0] owner_o;
  logic [2:0] credit_count_o;
  logic       credit_err_o;

  output_port_allocator dut (
    .clk             (clk),
    .rst             (rst),
    .req_i           (req_i),
    .tail_i          (tail_i),
    .credit_return_i (credit_return_i),
    .grant_o         (grant_o),
    .grant_v_o       (grant_v_o),
    .locked_o        (locked_o),
    .owner_o         (owner_o),
    .credit_count_o  (credit_count_o),
    .credit_err_o    (credit_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference state: packet lock, owner, search start, free downstream slots, error flag.
  int m_locked, m_owner, m_ptr, m_cred, m_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_owner  = 0;
    m_ptr    = 0;
    m_cred   = 4;
    m_err    = 0;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle against the model, advance the model.
  task automatic cycle(input logic [4:0] req, input logic [4:0] tail, input logic ret,
                       output logic [4:0] g);
    logic [4:0] eg;
    int w;
    req_i = req;
    tail_i = tail;
    credit_return_i = ret;
    @(negedge clk);
    eg = '0;
    w  = -1;
    if (m_cred > 0) begin
      if (m_locked != 0) begin
        if (req[m_owner]) w = m_owner;
      end else begin
        for (int i = 0; i < 5; i++)
          if (w < 0 && req[(m_ptr + i) % 5]) w = (m_ptr + i) % 5;
      end
    end
    if (w >= 0) eg[w] = 1'b1;
    g = grant_o;
    check_val("grant", 32'(grant_o), 32'(eg));
    check_val("grant_v", 32'(grant_v_o), 32'(eg != 0));
    check_val("locked", 32'(locked_o), 32'(m_locked));
    if (m_locked != 0) check_val("owner", 32'(owner_o), 32'(m_owner));
    check_val("credits", 32'(credit_count_o), 32'(m_cred));
    check_val("credit_err", 32'(credit_err_o), 32'(m_err));
    if (w >= 0) begin
      if (tail[w]) begin
        m_locked = 0;
        m_ptr    = (w + 1) % 5;
      end else begin
        m_locked = 1;
        m_owner  = w;
      end
    end
    if (w >= 0 && !ret) m_cred--;
    else if (w < 0 && ret) begin
      if (m_cred == 4) m_err = 1;
      else m_cred++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] g;
    n_vec = 0;
    n_err = 0;
    model_reset();
    rst = 1'b1;
    req_i = 5'b11111;
    tail_i = 5'b11111;
    credit_return_i = 1'b0;
    #12;
    check_val("rst_grant", 32'(grant_o), 32'd0);
    check_val("rst_locked", 32'(locked_o), 32'd0);
    check_val("rst_credits", 32'(credit_count_o), 32'd4);
    check_val("rst_err", 32'(credit_err_o), 32'd0);
    req_i = '0;
    tail_i = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-flit packets from inputs 1 and 2.
    cycle(5'b00110, 5'b00110, 1'b0, g); check_val("sf_c0", 32'(g), 32'b00010);
    cycle(5'b00110, 5'b00110, 1'b0, g); check_val("sf_c1", 32'(g), 32'b00100);

    // Input 0 locks for a 3-flit packet; input 1 waits.
    cycle(5'b00011, 5'b00000, 1'b1, g); check_val("lk_f1", 32'(g), 32'b00001);
    cycle(5'b00011, 5'b00000, 1'b1, g); check_val("lk_f2", 32'(g), 32'b00001);
    check_val("lk_owner", 32'(owner_o), 32'd0);
    cycle(5'b00011, 5'b00001, 1'b0, g); check_val("lk_f3", 32'(g), 32'b00001);
    cycle(5'b00011, 5'b00010, 1'b0, g); check_val("lk_next", 32'(g), 32'b00010);

    // Out of credits, then a single return.
    cycle(5'b00001, 5'b00001, 1'b0, g); check_val("nocred", 32'(g), 32'b00000);
    cycle(5'b00001, 5'b00001, 1'b1, g); check_val("nocred_ret", 32'(g), 32'b00000);
    cycle(5'b00001, 5'b00001, 1'b0, g); check_val("cred_back", 32'(g), 32'b00001);

    // Simultaneous transfer and return.
    cycle(5'b00000, 5'b00000, 1'b1, g);
    cycle(5'b00000, 5'b00000, 1'b1, g);
    cycle(5'b00010, 5'b00010, 1'b1, g);
    check_val("simul_cnt", 32'(credit_count_o), 32'd2);

    // Bubble inside a packet owned by input 2.
    cycle(5'b00000, 5'b00000, 1'b1, g);
    cycle(5'b00000, 5'b00000, 1'b1, g);
    cycle(5'b00100, 5'b00000, 1'b0, g); check_val("bub_head", 32'(g), 32'b00100);
    cycle(5'b00001, 5'b00000, 1'b0, g); check_val("bub_0", 32'(g), 32'b00000);
    cycle(5'b00001, 5'b00000, 1'b0, g); check_val("bub_1", 32'(g), 32'b00000);
    check_val("bub_locked", 32'(locked_o), 32'd1);
    cycle(5'b00101, 5'b00100, 1'b1, g); check_val("bub_resume", 32'(g), 32'b00100);

    // Overflow return at full count.
    cycle(5'b00000, 5'b00000, 1'b1, g);
    cycle(5'b00000, 5'b00000, 1'b1, g);
    check_val("ovf_cnt", 32'(credit_count_o), 32'd4);
    check_val("ovf_err", 32'(credit_err_o), 32'd1);
    cycle(5'b00000, 5'b00000, 1'b0, g);

    // Async reset in the middle of a packet.
    cycle(5'b00001, 5'b00000, 1'b0, g); check_val("ar_head", 32'(g), 32'b00001);
    #2;
    rst = 1'b1;
    #1;
    check_val("ar_grant", 32'(grant_o), 32'd0);
    check_val("ar_locked", 32'(locked_o), 32'd0);
    check_val("ar_credits", 32'(credit_count_o), 32'd4);
    check_val("ar_err", 32'(credit_err_o), 32'd0);
    req_i = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(5'b10000, 5'b10000, 1'b0, g); check_val("ar_after", 32'(g), 32'b10000);

    // Random traffic with tails biased low so packets span several flits.
    for (int i = 0; i < 3000; i++) begin
      cycle(5'($urandom), 5'($urandom) & 5'($urandom), ($urandom_range(0, 2) == 0), g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
